serial_mag_comparator_ctrl: RTL and testbench

SERIAL_MAG_COMPARATOR_CTRL -- requirements
Module: serial_mag_comparator_ctrl

---
 rtl/serial_cmp_pkg.sv | 13 +
 rtl/serial_bit_cmp_cell.sv | 15 +
 rtl/serial_mag_comparator_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_mag_comparator_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// FSM state encoding and default operand width.
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/serial_bit_cmp_cell.sv
// One-bit magnitude compare cell: greater, less and equal flags.
// Purely combinational; the controller walks it over the operands MSB first.
module serial_bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic l,
  output logic e
);

  assign g = a & ~b;
  assign l = ~a & b;
  assign e = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comparator_ctrl.sv
// Serial unsigned magnitude comparator, one bit per cycle, MSB first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_comparator_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  cmp_state_e state_q;
  cmp_state_e state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx_q;
  logic             decided_q;
  logic             res_gt_q;
  logic             res_lt_q;

  logic bit_a;
  logic bit_b;
  logic g;
  logic l;
  logic e;
  logic hit;
  logic last;
  logic fin_gt;
  logic fin_lt;
  logic fin_eq;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  serial_bit_cmp_cell u_cell (
    .a (bit_a),
    .b (bit_b),
    .g (g),
    .l (l),
    .e (e)
  );

  // First difference wins; later bits cannot overturn it.
  assign hit    = ~e & ~decided_q;
  assign last   = (idx_q == '0) | (EARLY & hit);
  assign fin_gt = decided_q ? res_gt_q : g;
  assign fin_lt = decided_q ? res_lt_q : l;
  assign fin_eq = ~decided_q & e;

  assign busy = (state_q == COMPARE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COMPARE;
      COMPARE: if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_gt_q  <= 1'b0;
      res_lt_q  <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            idx_q     <= IDX_MAX;
            decided_q <= 1'b0;
            res_gt_q  <= 1'b0;
            res_lt_q  <= 1'b0;
          end
        end
        COMPARE: begin
          if (hit) begin
            decided_q <= 1'b1;
            res_gt_q  <= g;
            res_lt_q  <= l;
          end
          if (idx_q != '0) begin
            idx_q <= idx_q - 1'b1;
          end
          if (last) begin
            gt <= fin_gt;
            lt <= fin_lt;
            eq <= fin_eq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Directed bench for serial_mag_comparator_ctrl (WIDTH=8).
// Expected latencies follow SERIAL_CMP_EARLY_EXIT_EN when defined.
module tb_serial_mag_comparator_ctrl;

  localparam int W = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         gt;
  logic         lt;
  logic         eq;

  int checks = 0;
  int errors = 0;

  serial_mag_comparator_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // k = first differing bit index, -1 when equal
  function automatic int exp_cycles(input int k);
    if (EARLY && k >= 0) return W - k;
    return W;
  endfunction

  // Count busy cycles up to the done pulse; bounded.
  task automatic wait_done(input string tag, output int nbusy, output bit ok);
    nbusy = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    check({tag, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic run_cmp(input string tag, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input int k,
                         input bit egt, input bit elt, input bit eeq);
    int  nb;
    bit  ok;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = ~va;
    b = ~vb;
    wait_done(tag, nb, ok);
    check({tag, "_cycles"}, nb, exp_cycles(k));
    check({tag, "_gt"}, int'(gt), int'(egt));
    check({tag, "_lt"}, int'(lt), int'(elt));
    check({tag, "_eq"}, int'(eq), int'(eeq));
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(done), 0);
    check({tag, "_hold"}, int'({gt, lt, eq}), int'({egt, elt, eeq}));
  endtask

  initial begin
    int nb;
    int ndone;
    bit ok;

    #12;
    check("rst_outs", int'({busy, done, gt, lt, eq}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmp("eq_a5", 8'hA5, 8'hA5, -1, 1'b0, 1'b0, 1'b1);
    run_cmp("gt_80", 8'h80, 8'h7F, 7, 1'b1, 1'b0, 1'b0);
    run_cmp("lt_3c", 8'h3C, 8'h3D, 0, 1'b0, 1'b1, 1'b0);
    run_cmp("gt_ff", 8'hFF, 8'h00, 7, 1'b1, 1'b0, 1'b0);
    run_cmp("lt_mid", 8'h12, 8'h1A, 3, 1'b0, 1'b1, 1'b0);

    // start held high, operands change mid-compare
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) begin
        a = 8'hFF;
        b = 8'h00;
      end
      if (done) begin
        ndone++;
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
    end
    check("hold_done_seen", int'(ok), 1);
    check("hold_cycles", nb, exp_cycles(1));
    check("hold_lt", int'({gt, lt, eq}), 3'b010);
    @(negedge clk);
    check("hold_idle", int'({busy, done}), 0);
    @(negedge clk);
    check("hold_reaccept", int'(busy), 1);
    start = 1'b0;
    wait_done("reacc", nb, ok);
    check("reacc_cycles", nb + 1, exp_cycles(7));
    check("reacc_gt", int'({gt, lt, eq}), 3'b100);

    // leave lt=1 so the reset clear is observable
    run_cmp("pre_rst", 8'h00, 8'h01, 0, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    a = 8'hA0;
    b = 8'hA0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async", int'({busy, done, gt, lt, eq}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 0);
    check("rst_idle", int'(busy), 0);

    run_cmp("post_rst", 8'h10, 8'h01, 4, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
